// File: rtl/aux_out_router_if.sv
`default_nettype none
// ============================================================================
// Module      : aux_out_router_if
// Description : Bundle of the aux-output router's detect, override, aux-source
//               and bank-output signals. The router connects via the slave
//               modport; the aux source / board side uses the master modport.
// Revision    : 1.0  initial release
// ============================================================================
interface aux_out_router_if #(
  parameter int N_CH = 2
);
  logic            board_detect;
  logic            force_en;
  logic            force_sel;
  logic [N_CH-1:0] aux_in;
  logic [N_CH-1:0] bank1_out;
  logic            bank1_oe;
  logic [N_CH-1:0] bank2_out;
  logic            bank2_oe;
  logic            sel_valid;
  logic            switching;
  logic [7:0]      switch_cnt;

  modport master (
    output board_detect, force_en, force_sel, aux_in,
    input  bank1_out, bank1_oe, bank2_out, bank2_oe,
    input  sel_valid, switching, switch_cnt
  );

  modport slave (
    input  board_detect, force_en, force_sel, aux_in,
    output bank1_out, bank1_oe, bank2_out, bank2_oe,
    output sel_valid, switching, switch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/aux_out_router.sv
`default_nettype none
// ============================================================================
// Module      : aux_out_router
// Description : Routes N_CH aux signals to one of two output banks selected by
//               a debounced board-detect pin (or a manual override), with
//               per-bank polarity correction and a break-before-make dead
//               time on every change of the driven bank.
// Revision    : 1.0  initial release
// ============================================================================
module aux_out_router #(
  parameter int              N_CH        = 2,
  parameter int              DEBOUNCE    = 16,
  parameter int              DEAD_CYCLES = 4,
  parameter logic [N_CH-1:0] INV1        = {N_CH{1'b0}},
  parameter logic [N_CH-1:0] INV2        = {N_CH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  aux_out_router_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam int DW = $clog2(DEAD_CYCLES) + 1;
  localparam logic [CW-1:0] C_DEB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] C_DEAD_INIT = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DRIVE1 = 2'd1,
    ST_DRIVE2 = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  // Synchroniser and debouncer state
  (* IOB = "TRUE" *) logic s1_q;
  logic          s2_q;
  logic          cand_q;
  logic [CW-1:0] cnt_q;
  logic          stable_sel_q;
  logic          stable_valid_q;

  // FSM state and registered outputs
  state_t          state_q, state_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic            sw_inc_d;
  (* IOB = "TRUE" *) logic [N_CH-1:0] bank1_out_q;
  (* IOB = "TRUE" *) logic            bank1_oe_q;
  (* IOB = "TRUE" *) logic [N_CH-1:0] bank2_out_q;
  (* IOB = "TRUE" *) logic            bank2_oe_q;
  logic            sel_valid_q;
  logic            switching_q;
  logic [7:0]      switch_cnt_q;

  // Override is applied combinationally so it reaches the FSM at the next edge
  logic eff_sel, eff_valid;
  assign eff_sel   = bus.force_en ? bus.force_sel : stable_sel_q;
  assign eff_valid = bus.force_en | stable_valid_q;

  // Two-flop synchroniser followed by a hold-time debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      cand_q         <= 1'b0;
      cnt_q          <= '0;
      stable_sel_q   <= 1'b0;
      stable_valid_q <= 1'b0;
    end else begin
      s1_q <= bus.board_detect;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q < C_DEB_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        stable_sel_q   <= cand_q;
        stable_valid_q <= 1'b1;
      end
    end
  end

  // Next-state logic: any change of driven bank passes through DEAD
  always_comb begin
    state_d  = state_q;
    dead_d   = dead_q;
    sw_inc_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (eff_valid) state_d = eff_sel ? ST_DRIVE1 : ST_DRIVE2;
      end
      ST_DRIVE1: begin
        if (!eff_valid || !eff_sel) begin
          state_d = ST_DEAD;
          dead_d  = C_DEAD_INIT;
        end
      end
      ST_DRIVE2: begin
        if (!eff_valid || eff_sel) begin
          state_d = ST_DEAD;
          dead_d  = C_DEAD_INIT;
        end
      end
      ST_DEAD: begin
        // Selection is only looked at on the exit edge; no restart on toggles
        if (dead_q == '0) begin
          if (!eff_valid) begin
            state_d = ST_OFF;
          end else begin
            state_d  = eff_sel ? ST_DRIVE1 : ST_DRIVE2;
            sw_inc_d = 1'b1;
          end
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // FSM register and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      dead_q       <= '0;
      bank1_out_q  <= '0;
      bank1_oe_q   <= 1'b0;
      bank2_out_q  <= '0;
      bank2_oe_q   <= 1'b0;
      sel_valid_q  <= 1'b0;
      switching_q  <= 1'b0;
      switch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dead_q      <= dead_d;
      bank1_oe_q  <= (state_d == ST_DRIVE1);
      bank2_oe_q  <= (state_d == ST_DRIVE2);
      bank1_out_q <= (state_d == ST_DRIVE1) ? (bus.aux_in ^ INV1) : '0;
      bank2_out_q <= (state_d == ST_DRIVE2) ? (bus.aux_in ^ INV2) : '0;
      sel_valid_q <= eff_valid;
      switching_q <= (state_d == ST_DEAD);
      if (sw_inc_d && (switch_cnt_q != 8'hFF)) switch_cnt_q <= switch_cnt_q + 8'd1;
    end
  end

  assign bus.bank1_out  = bank1_out_q;
  assign bus.bank1_oe   = bank1_oe_q;
  assign bus.bank2_out  = bank2_out_q;
  assign bus.bank2_oe   = bank2_oe_q;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.switching  = switching_q;
  assign bus.switch_cnt = switch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aux_out_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_aux_out_router
// Description : Self-checking bench for aux_out_router: timed hand sequences,
//               a data-path vector table, counter saturation, and randomized
//               stimulus against a behavioural model compared every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aux_out_router;

  localparam int        N   = 2;
  localparam int        DEB = 16;
  localparam int        DC  = 4;
  localparam logic [1:0] C_INV1 = 2'b00;
  localparam logic [1:0] C_INV2 = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  aux_out_router_if #(.N_CH(N)) bus ();

  aux_out_router #(
    .N_CH(N), .DEBOUNCE(DEB), .DEAD_CYCLES(DC), .INV1(C_INV1), .INV2(C_INV2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] dut_vec();
    return {bus.bank1_oe, bus.bank2_oe, bus.bank1_out, bus.bank2_out,
            bus.sel_valid, bus.switching, bus.switch_cnt};
  endfunction

  // ---------------- behavioural reference model ----------------
  // mode: 0 off, 1 driving bank 1, 2 driving bank 2, 3 dead time
  logic       m_s1, m_s2, m_level, m_stable, m_valid, m_es, m_ev;
  int         m_run, m_mode, m_dead;
  logic [7:0] m_cnt;
  logic       m_oe1, m_oe2, m_sv, m_sw;
  logic [1:0] m_out1, m_out2;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 1; m_stable = 0; m_valid = 0;
      m_mode = 0; m_dead = 0; m_cnt = 0;
      m_oe1 = 0; m_oe2 = 0; m_out1 = 0; m_out2 = 0; m_sv = 0; m_sw = 0;
    end else begin
      m_ev = bus.force_en | m_valid;
      m_es = bus.force_en ? bus.force_sel : m_stable;
      if (m_mode == 3) begin
        if (m_dead == 0) begin
          if (!m_ev) m_mode = 0;
          else begin
            m_mode = m_es ? 1 : 2;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
          end
        end else m_dead = m_dead - 1;
      end else if (m_mode == 0) begin
        if (m_ev) m_mode = m_es ? 1 : 2;
      end else if ((m_mode == 1) ? (!m_ev || !m_es) : (!m_ev || m_es)) begin
        m_mode = 3;
        m_dead = DC - 1;
      end
      m_oe1  = (m_mode == 1);
      m_oe2  = (m_mode == 2);
      m_out1 = m_oe1 ? (bus.aux_in ^ C_INV1) : 2'b00;
      m_out2 = m_oe2 ? (bus.aux_in ^ C_INV2) : 2'b00;
      m_sv   = m_ev;
      m_sw   = (m_mode == 3);
      // a level is accepted once DEB+1 consecutive synchronised samples agree
      if (m_s2 == m_level) begin
        if (m_run < 1000) m_run = m_run + 1;
      end else begin
        m_level = m_s2;
        m_run   = 1;
      end
      if (m_run >= DEB + 1) begin
        m_stable = m_level;
        m_valid  = 1;
      end
      m_s2 = m_s1;
      m_s1 = bus.board_detect;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model_outputs", 64'(dut_vec()),
            64'({m_oe1, m_oe2, m_out1, m_out2, m_sv, m_sw, m_cnt}));
  end

  // ---------------- directed sequences ----------------
  // Expects rst to have just been released with detect=1 and no override;
  // oe1 is first high 19 cycles after the first edge with rst low.
  task automatic bringup(input string tag);
    int early;
    early = 0;
    for (int e = 0; e < 19; e++) begin
      step();
      if (bus.bank1_oe || bus.bank2_oe) early++;
    end
    check({tag, "_no_early_oe"}, 64'(early), 64'd0);
    step();
    check({tag, "_oe1"}, 64'(bus.bank1_oe), 64'd1);
    check({tag, "_oe2"}, 64'(bus.bank2_oe), 64'd0);
    bus.aux_in = 2'b10;
    step();
    check({tag, "_data1"}, 64'(bus.bank1_out), 64'h2);
  endtask

  typedef struct {
    logic       sel;
    logic [1:0] aux;
    logic [1:0] exp1;
    logic [1:0] exp2;
    logic       exp_oe1;
    logic       exp_oe2;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int   bad;
    logic cur;
    int   len;

    tbl[0] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};

    bus.board_detect = 1'b1;
    bus.force_en     = 1'b0;
    bus.force_sel    = 1'b0;
    bus.aux_in       = 2'b00;
    rst              = 1'b1;
    step();
    chk_en = 1'b1;
    repeat (3) step();
    check("reset_outputs", 64'(dut_vec()), 64'd0);

    // Bank 1 bring-up
    rst = 1'b0;
    bringup("bringup");

    // Glitch: 10-cycle low pulse while driving bank 1
    bus.board_detect = 1'b0;
    repeat (10) step();
    bus.board_detect = 1'b1;
    bad = 0;
    repeat (40) begin
      step();
      if (!bus.bank1_oe || bus.bank2_oe || bus.switching) bad++;
    end
    check("glitch_no_change", 64'(bad), 64'd0);
    check("glitch_cnt", 64'(bus.switch_cnt), 64'd0);

    // Switchover to bank 2 by detect
    bus.aux_in = 2'b01;
    bus.board_detect = 1'b0;
    repeat (19) step();
    check("switch_oe1_held", 64'(bus.bank1_oe), 64'd1);
    step();
    check("switch_oe1_fall", 64'({bus.bank1_oe, bus.bank2_oe, bus.switching}), 64'b001);
    bad = 0;
    repeat (3) begin
      step();
      if (bus.bank1_oe || bus.bank2_oe || !bus.switching) bad++;
    end
    check("switch_dead_window", 64'(bad), 64'd0);
    step();
    check("switch_oe2_rise", 64'({bus.bank1_oe, bus.bank2_oe, bus.switching}), 64'b010);
    check("switch_cnt1", 64'(bus.switch_cnt), 64'd1);
    check("switch_polarity", 64'({bus.bank1_out, bus.bank2_out}), 64'b0010);

    // Override to bank 1, then release back to bank 2
    bus.force_en = 1'b1;
    bus.force_sel = 1'b1;
    step();
    check("ovr_dead_next", 64'({bus.bank1_oe, bus.bank2_oe, bus.switching}), 64'b001);
    repeat (3) step();
    check("ovr_still_dead", 64'(bus.switching), 64'd1);
    step();
    check("ovr_drive1", 64'({bus.bank1_oe, bus.bank2_oe, bus.switch_cnt}), 64'h202);
    bus.force_en = 1'b0;
    step();
    check("rel_dead_next", 64'({bus.bank1_oe, bus.bank2_oe, bus.switching}), 64'b001);
    repeat (4) step();
    check("rel_drive2", 64'({bus.bank1_oe, bus.bank2_oe, bus.switch_cnt}), 64'h103);

    // Reset in the middle of DEAD
    bus.force_en = 1'b1;
    bus.force_sel = 1'b1;
    repeat (2) step();
    check("pre_reset_dead", 64'(bus.switching), 64'd1);
    rst = 1'b1;
    step();
    check("reset_mid_dead", 64'(dut_vec()), 64'd0);
    bus.force_en = 1'b0;
    bus.board_detect = 1'b1;
    rst = 1'b0;
    bringup("rebringup");

    // Data-path vectors on both banks
    cur = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].sel != cur) begin
        bus.force_en = 1'b1;
        bus.force_sel = tbl[i].sel;
        repeat (6) step();
        cur = tbl[i].sel;
      end
      bus.aux_in = tbl[i].aux;
      step();
      check($sformatf("vec%0d", i),
            64'({bus.bank1_oe, bus.bank2_oe, bus.bank1_out, bus.bank2_out}),
            64'({tbl[i].exp_oe1, tbl[i].exp_oe2, tbl[i].exp1, tbl[i].exp2}));
    end
    bus.force_en = 1'b0;

    // switch_cnt saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.force_en = 1'b1;
    bus.force_sel = 1'b1;
    repeat (2) step();
    for (int t = 0; t < 260; t++) begin
      bus.force_sel = ~bus.force_sel;
      repeat (6) step();
      if (t == 254) check("cnt_reach_255", 64'(bus.switch_cnt), 64'd255);
    end
    check("cnt_saturated", 64'(bus.switch_cnt), 64'd255);
    bus.force_en = 1'b0;

    // Randomized stimulus, checked every cycle against the model
    for (int seg = 0; seg < 150; seg++) begin
      len = int'($urandom_range(1, 40));
      bus.board_detect = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        bus.force_en  = 1'b1;
        bus.force_sel = 1'($urandom_range(0, 1));
      end else begin
        bus.force_en = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        bus.aux_in = 2'($urandom);
        rst = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    rst = 1'b0;
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aux_out_router.md
# aux_out_router

Parametrised auxiliary-output router for boards that exist in two variants with different aux-output buffer banks. It synchronises and debounces the board-detect pin, drives exactly one of two N-channel output banks with per-bank polarity correction, and inserts a break-before-make dead time whenever the selected bank changes. A manual override and status outputs are provided. The block sits between the aux-output sources and the IOB output/enable registers of both banks.

## Interface
- `N_CH`, 2: channels per bank (1..32).
- `DEBOUNCE`, 16: consecutive synchronised cycles the detect level must hold before it is accepted (>=1).
- `DEAD_CYCLES`, 4: cycles both banks are released during a switchover (>=1).
- `INV1`, {N_CH{1'b0}}: per-channel inversion mask for bank 1.
- `INV2`, {N_CH{1'b1}}: per-channel inversion mask for bank 2, default all-ones because bank 2 uses inverting buffers.

- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `board_detect` in 1: asynchronous board-variant pin. 1 selects bank 1, 0 selects bank 2.
- `force_en` in 1: override enable, synchronous to `clk`.
- `force_sel` in 1: override bank selection when `force_en`=1. 1 selects bank 1.
- `aux_in` in N_CH: aux source signals.
- `bank1_out` out N_CH: bank 1 data, IOB register.
- `bank1_oe` out 1: bank 1 output enable, IOB register, active-high.
- `bank2_out` out N_CH: bank 2 data, IOB register.
- `bank2_oe` out 1: bank 2 output enable, IOB register.
- `sel_valid` out 1: a debounced selection exists, or the override is active.
- `switching` out 1: high while in the DEAD state.
- `switch_cnt` out 8: completed switchovers, saturating at 255.

## Operation
- **Synchroniser:** `board_detect` passes through two flops, `s1` then `s2`. `s1` carries the IOB attribute.
- **Debouncer:** registers `cand`, `cnt`, `stable_sel` and `stable_valid`.
  - If `s2` != `cand`: load `cand` <= `s2` and `cnt` <= 0.
  - Else if `cnt` < DEBOUNCE-1: increment `cnt`.
  - Else: `stable_sel` <= `cand` and `stable_valid` <= 1.
  - The counter width is $clog2(DEBOUNCE)+1.
- **Effective selection:** `eff_sel` = `force_en` ? `force_sel` : `stable_sel`. `eff_valid` = `force_en` | `stable_valid`. `sel_valid` is the registered copy of `eff_valid`.
- **State machine:** states OFF, DRIVE1, DRIVE2, DEAD.
  - OFF: when `eff_valid`, go to DRIVE1 if `eff_sel` else DRIVE2. There is no dead time on the first entry.
  - DRIVE1: go to DEAD when `eff_sel`=0 or `eff_valid`=0. DRIVE2 is symmetric.
  - DEAD: a down-counter is loaded with DEAD_CYCLES-1 on entry.
    - At zero, go to DRIVE1/DRIVE2 according to `eff_sel` sampled at that edge, or to OFF if `!eff_valid`.
    - If `eff_sel` toggles during DEAD, DEAD still completes. Only the value at exit matters, and no restart occurs.
  - `switch_cnt` increments on each DEAD->DRIVEx transition.
- **Outputs:** all are registered from next-state.
  - `bank1_oe` <= (next == DRIVE1). `bank2_oe` is the same for DRIVE2.
  - `bank1_out` <= (next == DRIVE1) ? `aux_in` ^ INV1 : 0. `bank2_out` is likewise with INV2.
  - Both enables are never high in the same cycle.
- **Reset:**
  - State OFF; `s1`, `s2`, `cand`, `cnt`, `stable_sel`, `stable_valid` all 0.
  - All outputs 0: both oe low, data 0, `sel_valid`/`switching`/`switch_cnt` 0.
  - A reset asserted mid-DEAD or mid-DRIVE takes effect at that edge.
  - After reset deasserts, debouncing restarts from scratch.

## Timing
- **Data latency:** `aux_in` to `bankX_out` is 1 cycle while driving.
- **Detect step:** a level change captured into `s1` at edge k produces `stable_sel` at edge k+DEBOUNCE+2.
  - Old-bank oe falls at edge k+DEBOUNCE+3.
  - New-bank oe rises at edge k+DEBOUNCE+3+DEAD_CYCLES.
  - `switching` is high for exactly DEAD_CYCLES cycles.
- **Glitch rejection:** a detect glitch shorter than DEBOUNCE synchronised cycles never changes `stable_sel`.
- **Override:** `force_en`/`force_sel` take effect into the FSM at the next edge, so the oe change appears 1 cycle after the input. The override bypasses debouncing but not DEAD.
- **Power-up:** from OFF, first oe rises DEBOUNCE+3 cycles after reset release, provided detect is steady.

## Test plan
- **Bank 1 bring-up:** reset, `board_detect`=1 steady, DEBOUNCE=16, DEAD=4 -> `bank1_oe`=1 at cycle 19 after release. `bank2_oe` stays 0. `aux_in`=2'b10 gives `bank1_out`=2'b10 one cycle later.
- **Bank 2 polarity:** `board_detect`=0 -> `bank2_oe`=1 and `bank2_out`=~`aux_in` (2'b01 -> 2'b10). `bank1_out`=0.
- **Switchover:** from DRIVE1, detect 1->0 -> `bank1_oe` falls at k+19. Both oe are 0 for 4 cycles with `switching`=1. `bank2_oe`=1 at k+23. `switch_cnt`=1.
- **Glitch:** a 10-cycle low pulse on detect while in DRIVE1 -> no oe change and `switch_cnt` unchanged.
- **Override:** `force_en`=1, `force_sel`=0 while in DRIVE1 -> DEAD entered next cycle, DRIVE2 after 4 cycles. Releasing `force_en` with detect=1 returns to DRIVE1 via DEAD.
- **Reset mid-DEAD:** assert `rst` during DEAD -> all outputs 0 next edge, state OFF, `switch_cnt`=0. The full debounce interval repeats after release.
